// File: rtl/fse_lms_updater.sv
// rtl/fse_lms_updater.sv - complex LMS tap updater for the FSE; optional leaky LMS via LMS_LEAK_EN
// Serial one-tap-per-clock adaptation with atomic tap commit and a one-cycle load strobe.
module fse_lms_updater #(
   parameter int NUM_TAPS = 9,
   parameter int NBT_IN   = 8,
   parameter int NBF_IN   = 7,
   parameter int NBT_TAPS = 8,
   parameter int NBF_TAPS = 5,
   parameter int NBT_Y    = 12,
   parameter int NBF_Y    = 9,
   parameter int NBT_ACC  = 20,
   parameter int NBF_ACC  = 17,
   parameter int MU_SHIFT = 8,
   parameter int DEC_LVL  = 362
`ifdef LMS_LEAK_EN
   ,
   parameter int LEAK_SHIFT = 12
`endif
) (
   input  logic                         clk,
   input  logic                         i_reset,
   input  logic [NBT_IN-1:0]            i_is_data_I,
   input  logic [NBT_IN-1:0]            i_is_data_Q,
   input  logic                         i_ctrl,
   input  logic                         i_baud,
   input  logic [NBT_Y-1:0]             i_fse_I,
   input  logic [NBT_Y-1:0]             i_fse_Q,
   input  logic                         i_en_rx,
   input  logic                         i_en_lms,
   output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_I,
   output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_Q,
   output logic                         o_en_taps,
   output logic                         o_overrun
);

   localparam int CTR     = NUM_TAPS / 2;
   localparam int KW      = $clog2(NUM_TAPS);
   localparam int NBT_E   = NBT_Y + 1;
   localparam int NBT_P   = NBT_E + NBT_IN + 1;
   localparam int SH_L    = NBF_ACC - NBF_Y - NBF_IN;
   localparam int NBT_D   = NBT_P + SH_L;
   localparam int NBT_W   = ((NBT_D > NBT_ACC) ? NBT_D : NBT_ACC) + 2;
   localparam int SH_T    = NBF_ACC - NBF_TAPS;
   localparam int ACC_MAX = 2**(NBT_ACC-1) - 1;
   localparam int ACC_MIN = -(2**(NBT_ACC-1));
   localparam int TAP_MAX = 2**(NBT_TAPS-1) - 1;
   localparam int TAP_MIN = -(2**(NBT_TAPS-1));
   localparam logic [KW-1:0] K_LAST = KW'(NUM_TAPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ERR, S_UPD, S_COMMIT} state_t;

   state_t                    r_state;
   logic [KW-1:0]             r_k;
   logic signed [NBT_IN-1:0]  r_xI [NUM_TAPS];
   logic signed [NBT_IN-1:0]  r_xQ [NUM_TAPS];
   logic signed [NBT_IN-1:0]  r_rI [NUM_TAPS];
   logic signed [NBT_IN-1:0]  r_rQ [NUM_TAPS];
   logic signed [NBT_Y-1:0]   r_yI, r_yQ;
   logic signed [NBT_E-1:0]   r_eI, r_eQ;
   logic signed [NBT_ACC-1:0] r_accI [NUM_TAPS];
   logic signed [NBT_ACC-1:0] r_accQ [NUM_TAPS];

   logic signed [NBT_P-1:0]   w_eIx, w_eQx, w_rIx, w_rQx, w_pR, w_pI;
   logic signed [NBT_W-1:0]   w_dR, w_dI, w_lkI, w_lkQ, w_nI, w_nQ;

   function automatic logic signed [NBT_ACC-1:0] sat_acc(input logic signed [NBT_W-1:0] v);
      if (v > NBT_W'(ACC_MAX)) return NBT_ACC'(ACC_MAX);
      if (v < NBT_W'(ACC_MIN)) return NBT_ACC'(ACC_MIN);
      return NBT_ACC'(v);
   endfunction

   function automatic logic [NBT_TAPS-1:0] sat_tap(input logic signed [NBT_ACC-1:0] v);
      logic signed [NBT_ACC-1:0] s;
      s = v >>> SH_T;
      if (s > NBT_ACC'(TAP_MAX)) return NBT_TAPS'(TAP_MAX);
      if (s < NBT_ACC'(TAP_MIN)) return NBT_TAPS'(TAP_MIN);
      return s[NBT_TAPS-1:0];
   endfunction

   // e * conj(r[k]) for the tap currently being updated
   assign w_eIx = NBT_P'(r_eI);
   assign w_eQx = NBT_P'(r_eQ);
   assign w_rIx = NBT_P'(r_rI[r_k]);
   assign w_rQx = NBT_P'(r_rQ[r_k]);
   assign w_pR  = w_eIx * w_rIx + w_eQx * w_rQx;
   assign w_pI  = w_eQx * w_rIx - w_eIx * w_rQx;
   assign w_dR  = (NBT_W'(w_pR) <<< SH_L) >>> MU_SHIFT;
   assign w_dI  = (NBT_W'(w_pI) <<< SH_L) >>> MU_SHIFT;

`ifdef LMS_LEAK_EN
   assign w_lkI = NBT_W'(r_accI[r_k]) >>> LEAK_SHIFT;
   assign w_lkQ = NBT_W'(r_accQ[r_k]) >>> LEAK_SHIFT;
`else
   assign w_lkI = '0;
   assign w_lkQ = '0;
`endif

   assign w_nI = NBT_W'(r_accI[r_k]) - w_dR - w_lkI;
   assign w_nQ = NBT_W'(r_accQ[r_k]) - w_dI - w_lkQ;

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_k       <= '0;
         r_yI      <= '0;
         r_yQ      <= '0;
         r_eI      <= '0;
         r_eQ      <= '0;
         o_en_taps <= 1'b0;
         o_overrun <= 1'b0;
         o_taps_Q  <= '0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            r_xI[k]   <= '0;
            r_xQ[k]   <= '0;
            r_rI[k]   <= '0;
            r_rQ[k]   <= '0;
            r_accI[k] <= (k == CTR) ? NBT_ACC'(1 << NBF_ACC) : '0;
            r_accQ[k] <= '0;
            o_taps_I[k*NBT_TAPS +: NBT_TAPS] <= (k == CTR) ? NBT_TAPS'(1 << NBF_TAPS) : '0;
         end
      end else if (!i_en_rx) begin
         r_state   <= S_IDLE;
         r_k       <= '0;
         r_yI      <= '0;
         r_yQ      <= '0;
         r_eI      <= '0;
         r_eQ      <= '0;
         o_en_taps <= 1'b0;
         o_overrun <= 1'b0;
         o_taps_Q  <= '0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            r_xI[k]   <= '0;
            r_xQ[k]   <= '0;
            r_rI[k]   <= '0;
            r_rQ[k]   <= '0;
            r_accI[k] <= (k == CTR) ? NBT_ACC'(1 << NBF_ACC) : '0;
            r_accQ[k] <= '0;
            o_taps_I[k*NBT_TAPS +: NBT_TAPS] <= (k == CTR) ? NBT_TAPS'(1 << NBF_TAPS) : '0;
         end
      end else begin
         if (i_ctrl) begin
            r_xI[0] <= i_is_data_I;
            r_xQ[0] <= i_is_data_Q;
            for (int k = 1; k < NUM_TAPS; k++) begin
               r_xI[k] <= r_xI[k-1];
               r_xQ[k] <= r_xQ[k-1];
            end
         end
         if (i_baud && r_state != S_IDLE) o_overrun <= 1'b1;
         o_en_taps <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_baud && i_en_lms) begin
                  r_yI    <= i_fse_I;
                  r_yQ    <= i_fse_Q;
                  r_rI    <= r_xI;
                  r_rQ    <= r_xQ;
                  r_state <= S_ERR;
               end
            end
            S_ERR: begin
               // y == 0 slices to the positive decision
               r_eI    <= NBT_E'(r_yI) - (r_yI[NBT_Y-1] ? NBT_E'(-DEC_LVL) : NBT_E'(DEC_LVL));
               r_eQ    <= NBT_E'(r_yQ) - (r_yQ[NBT_Y-1] ? NBT_E'(-DEC_LVL) : NBT_E'(DEC_LVL));
               r_k     <= '0;
               r_state <= S_UPD;
            end
            S_UPD: begin
               r_accI[r_k] <= sat_acc(w_nI);
               r_accQ[r_k] <= sat_acc(w_nQ);
               if (r_k == K_LAST) r_state <= S_COMMIT;
               else               r_k     <= r_k + KW'(1);
            end
            S_COMMIT: begin
               for (int k = 0; k < NUM_TAPS; k++) begin
                  o_taps_I[k*NBT_TAPS +: NBT_TAPS] <= sat_tap(r_accI[k]);
                  o_taps_Q[k*NBT_TAPS +: NBT_TAPS] <= sat_tap(r_accQ[k]);
               end
               o_en_taps <= 1'b1;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fse_lms_updater.sv
// tb/tb_fse_lms_updater.sv - bench for fse_lms_updater (MU_SHIFT=0 and default instances)
// Reference model applies each whole LMS update arithmetically at baud acceptance.
module tb_fse_lms_updater;
   localparam int NT    = 9;
   localparam int ALIGN = 2;
   localparam logic [71:0] RST_I = {32'h0, 8'h20, 32'h0};

   logic        clk = 1'b0;
   logic        i_reset = 1'b0;
   logic [7:0]  i_is_data_I = '0, i_is_data_Q = '0;
   logic        i_ctrl = 1'b0, i_baud = 1'b0, i_en_rx = 1'b1, i_en_lms = 1'b1;
   logic [11:0] i_fse_I = '0, i_fse_Q = '0;
   logic [71:0] o_taps_I0, o_taps_Q0, o_taps_I8, o_taps_Q8;
   logic        o_en_taps0, o_en_taps8, o_overrun0, o_overrun8;

   int n_vec = 0, n_err = 0;
   longint m_accI[2][NT], m_accQ[2][NT];
   int m_tapI[2][NT], m_tapQ[2][NT], p_tapI[2][NT], p_tapQ[2][NT];
   int m_xI[NT], m_xQ[NT];
   int m_cnt;
   bit m_ovr, m_strobe;

   fse_lms_updater #(.MU_SHIFT(0)) dut0 (
      .clk(clk), .i_reset(i_reset), .i_is_data_I(i_is_data_I), .i_is_data_Q(i_is_data_Q),
      .i_ctrl(i_ctrl), .i_baud(i_baud), .i_fse_I(i_fse_I), .i_fse_Q(i_fse_Q),
      .i_en_rx(i_en_rx), .i_en_lms(i_en_lms), .o_taps_I(o_taps_I0), .o_taps_Q(o_taps_Q0),
      .o_en_taps(o_en_taps0), .o_overrun(o_overrun0));

   fse_lms_updater dut8 (
      .clk(clk), .i_reset(i_reset), .i_is_data_I(i_is_data_I), .i_is_data_Q(i_is_data_Q),
      .i_ctrl(i_ctrl), .i_baud(i_baud), .i_fse_I(i_fse_I), .i_fse_Q(i_fse_Q),
      .i_en_rx(i_en_rx), .i_en_lms(i_en_lms), .o_taps_I(o_taps_I8), .o_taps_Q(o_taps_Q8),
      .o_en_taps(o_en_taps8), .o_overrun(o_overrun8));

   always #5 clk = ~clk;

   function automatic longint fdiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
      return q;
   endfunction

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic logic [71:0] pack_exp(input int u, input bit q);
      logic [71:0] v;
      int t;
      for (int k = 0; k < NT; k++) begin
         t = q ? m_tapQ[u][k] : m_tapI[u][k];
         v[k*8 +: 8] = t[7:0];
      end
      return v;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NT; k++) begin
         m_xI[k] = 0;
         m_xQ[k] = 0;
         for (int u = 0; u < 2; u++) begin
            m_accI[u][k] = (k == NT/2) ? 131072 : 0;
            m_accQ[u][k] = 0;
            m_tapI[u][k] = (k == NT/2) ? 32 : 0;
            m_tapQ[u][k] = 0;
         end
      end
      m_cnt = 0;
      m_ovr = 0;
      m_strobe = 0;
   endtask

   task automatic model_accept(input int yi, input int yq);
      int eI, eQ;
      longint pR, pI, a, b;
      eI = yi - ((yi >= 0) ? 362 : -362);
      eQ = yq - ((yq >= 0) ? 362 : -362);
      for (int k = 0; k < NT; k++) begin
         pR = longint'(eI) * m_xI[k] + longint'(eQ) * m_xQ[k];
         pI = longint'(eQ) * m_xI[k] - longint'(eI) * m_xQ[k];
         for (int u = 0; u < 2; u++) begin
            a = m_accI[u][k] - fdiv(pR * ALIGN, longint'(1) << (u * 8));
            b = m_accQ[u][k] - fdiv(pI * ALIGN, longint'(1) << (u * 8));
`ifdef LMS_LEAK_EN
            a = a - fdiv(m_accI[u][k], 4096);
            b = b - fdiv(m_accQ[u][k], 4096);
`endif
            m_accI[u][k] = clamp(a, -524288, 524287);
            m_accQ[u][k] = clamp(b, -524288, 524287);
            p_tapI[u][k] = int'(clamp(fdiv(m_accI[u][k], 4096), -128, 127));
            p_tapQ[u][k] = int'(clamp(fdiv(m_accQ[u][k], 4096), -128, 127));
         end
      end
      m_cnt = 12;
   endtask

   // Drives one clock of stimulus, advances the model, returns #1 after the edge.
   task automatic cycle(input bit ctrl, input int xi, input int xq, input bit baud,
                        input int yi, input int yq, input bit en_lms, input bit en_rx);
      i_ctrl = ctrl; i_is_data_I = xi[7:0]; i_is_data_Q = xq[7:0];
      i_baud = baud; i_fse_I = yi[11:0]; i_fse_Q = yq[11:0];
      i_en_lms = en_lms; i_en_rx = en_rx;
      @(posedge clk);
      m_strobe = 0;
      if (!en_rx) model_clear();
      else begin
         if (baud && m_cnt != 0) m_ovr = 1;
         if (baud && en_lms && m_cnt == 0) model_accept(yi, yq);
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_tapI = p_tapI;
               m_tapQ = p_tapQ;
               m_strobe = 1;
            end
         end
         if (ctrl) begin
            for (int k = NT-1; k > 0; k--) begin
               m_xI[k] = m_xI[k-1];
               m_xQ[k] = m_xQ[k-1];
            end
            m_xI[0] = xi;
            m_xQ[0] = xq;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_reset = 1; i_baud = 0; i_ctrl = 0; i_en_rx = 1; i_en_lms = 1;
      #1;
      model_clear();
      #2;
      i_reset = 0;
   endtask

   task automatic load_single();
      do_reset();
      cycle(1, 64, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, 0, 1, 1);
   endtask

   task automatic test_reset();
      @(negedge clk);
      i_reset = 1;
      #1;
      model_clear();
      n_vec += 4;
      if (o_taps_I0 !== RST_I || o_taps_I8 !== RST_I) begin
         n_err++; $display("FAIL reset_taps_I: got %h/%h want %h", o_taps_I0, o_taps_I8, RST_I);
      end
      if (o_taps_Q0 !== 72'h0 || o_taps_Q8 !== 72'h0) begin
         n_err++; $display("FAIL reset_taps_Q: got %h/%h want 0", o_taps_Q0, o_taps_Q8);
      end
      if (o_en_taps0 !== 1'b0 || o_en_taps8 !== 1'b0) begin
         n_err++; $display("FAIL reset_en_taps: got %b/%b want 0", o_en_taps0, o_en_taps8);
      end
      if (o_overrun0 !== 1'b0 || o_overrun8 !== 1'b0) begin
         n_err++; $display("FAIL reset_overrun: got %b/%b want 0", o_overrun0, o_overrun8);
      end
      #2;
      i_reset = 0;
   endtask

   task automatic test_single_update();
      int at_n, cnt;
      at_n = -1; cnt = 0;
      load_single();
      cycle(0, 0, 0, 1, 256, 0, 1, 1);
      for (int n = 1; n <= 14; n++) begin
         cycle(0, 0, 0, 0, 0, 0, 1, 1);
         if (o_en_taps0 === 1'b1) begin at_n = n; cnt++; end
         n_vec++;
         if (o_en_taps0 !== m_strobe || o_en_taps8 !== m_strobe) begin
            n_err++; $display("FAIL single_strobe n=%0d: got %b/%b want %b", n, o_en_taps0, o_en_taps8, m_strobe);
         end
      end
      n_vec += 5;
      if (at_n !== 11 || cnt !== 1) begin
         n_err++; $display("FAIL single_latency: got cycle %0d count %0d want cycle 11 count 1", at_n, cnt);
      end
      if (o_taps_I0[39:32] !== 8'd35 || o_taps_Q0[39:32] !== 8'd11) begin
         n_err++; $display("FAIL single_tap4_mu0: got I=%0d Q=%0d want I=35 Q=11", o_taps_I0[39:32], o_taps_Q0[39:32]);
      end
      if (o_taps_I0 !== pack_exp(0, 0) || o_taps_Q0 !== pack_exp(0, 1)) begin
         n_err++; $display("FAIL single_taps_mu0: got %h %h want %h %h", o_taps_I0, o_taps_Q0, pack_exp(0, 0), pack_exp(0, 1));
      end
      if (o_taps_I8 !== RST_I || o_taps_Q8 !== 72'h0) begin
         n_err++; $display("FAIL single_taps_mu8: got %h %h want %h 0", o_taps_I8, o_taps_Q8, RST_I);
      end
      if (m_accI[1][4] != 131125 || m_accQ[1][4] != 181) begin
         n_err++; $display("FAIL single_model_acc_mu8: got %0d %0d want 131125 181", m_accI[1][4], m_accQ[1][4]);
      end
   endtask

   task automatic test_lms_disabled();
      int cnt;
      cnt = 0;
      do_reset();
      for (int b = 0; b < 100; b++) begin
         for (int j = 0; j < 16; j++) begin
            cycle(1'($urandom), $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                  j == 0, $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048, 0, 1);
            if (o_en_taps0 === 1'b1 || o_en_taps8 === 1'b1) cnt++;
         end
      end
      n_vec += 3;
      if (cnt !== 0) begin
         n_err++; $display("FAIL lms_off_strobes: got %0d want 0", cnt);
      end
      if (o_taps_I0 !== RST_I || o_taps_I8 !== RST_I || o_taps_Q0 !== 72'h0 || o_taps_Q8 !== 72'h0) begin
         n_err++; $display("FAIL lms_off_taps: got %h %h want %h 0", o_taps_I0, o_taps_Q0, RST_I);
      end
      if (o_overrun0 !== 1'b0 || o_overrun8 !== 1'b0) begin
         n_err++; $display("FAIL lms_off_overrun: got %b/%b want 0", o_overrun0, o_overrun8);
      end
   endtask

   task automatic test_overrun();
      int cnt;
      cnt = 0;
      load_single();
      cycle(0, 0, 0, 1, 256, 0, 1, 1);
      for (int n = 1; n <= 16; n++) begin
         cycle(0, 0, 0, n == 5, 2047, 2047, 1, 1);
         if (o_en_taps0 === 1'b1) cnt++;
      end
      n_vec += 4;
      if (o_overrun0 !== 1'b1 || o_overrun8 !== 1'b1 || m_ovr !== 1'b1) begin
         n_err++; $display("FAIL overrun_flag: got %b/%b want 1", o_overrun0, o_overrun8);
      end
      if (cnt !== 1) begin
         n_err++; $display("FAIL overrun_strobes: got %0d want 1", cnt);
      end
      if (o_taps_I0[39:32] !== 8'd35 || o_taps_Q0[39:32] !== 8'd11) begin
         n_err++; $display("FAIL overrun_tap4: got I=%0d Q=%0d want I=35 Q=11", o_taps_I0[39:32], o_taps_Q0[39:32]);
      end
      if (o_taps_I0 !== pack_exp(0, 0) || o_taps_Q8 !== pack_exp(1, 1)) begin
         n_err++; $display("FAIL overrun_taps: got %h %h want %h %h", o_taps_I0, o_taps_Q8, pack_exp(0, 0), pack_exp(1, 1));
      end
   endtask

   task automatic test_saturation();
      int cnt;
      cnt = 0;
      do_reset();
      for (int i = 0; i < NT; i++) cycle(1, 127, 0, 0, 0, 0, 1, 1);
      for (int b = 0; b < 10; b++) begin
         for (int j = 0; j < 12; j++) begin
            cycle(0, 0, 0, j == 0, 2047, -2048, 1, 1);
            if (m_strobe) begin
               n_vec++;
               if (o_taps_I0 !== pack_exp(0, 0) || o_taps_Q0 !== pack_exp(0, 1) ||
                   o_taps_I8 !== pack_exp(1, 0) || o_taps_Q8 !== pack_exp(1, 1)) begin
                  n_err++; $display("FAIL sat_taps b=%0d: got %h %h want %h %h", b, o_taps_I0, o_taps_Q0, pack_exp(0, 0), pack_exp(0, 1));
               end
            end
         end
      end
      n_vec += 2;
      if (o_taps_I0 !== {9{8'h80}}) begin
         n_err++; $display("FAIL sat_clamp_I: got %h want all 80", o_taps_I0);
      end
      if (o_taps_Q0 !== {9{8'h7F}}) begin
         n_err++; $display("FAIL sat_clamp_Q: got %h want all 7f", o_taps_Q0);
      end
      cycle(0, 0, 0, 1, 2047, -2048, 1, 1);
      for (int j = 0; j < 4; j++) cycle(0, 0, 0, 0, 0, 0, 1, 1);
      do_reset();
      for (int j = 0; j < 15; j++) begin
         cycle(0, 0, 0, 0, 0, 0, 1, 1);
         if (o_en_taps0 === 1'b1 || o_en_taps8 === 1'b1) cnt++;
      end
      n_vec += 2;
      if (cnt !== 0) begin
         n_err++; $display("FAIL midupd_reset_strobe: got %0d want 0", cnt);
      end
      if (o_taps_I0 !== RST_I || o_taps_Q0 !== 72'h0 || o_taps_I8 !== RST_I) begin
         n_err++; $display("FAIL midupd_reset_taps: got %h %h want %h 0", o_taps_I0, o_taps_Q0, RST_I);
      end
   endtask

   task automatic test_random();
      int gap;
      bit en;
      do_reset();
      for (int b = 0; b < 150; b++) begin
         gap = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 11) : $urandom_range(12, 20);
         en = ($urandom_range(0, 3) != 0);
         for (int j = 0; j < gap; j++) begin
            cycle(1'($urandom), $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                  j == 0, $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048,
                  en, $urandom_range(0, 299) != 0);
            n_vec += 3;
            if (o_en_taps0 !== m_strobe || o_en_taps8 !== m_strobe) begin
               n_err++; $display("FAIL rnd_strobe b=%0d: got %b/%b want %b", b, o_en_taps0, o_en_taps8, m_strobe);
            end
            if (o_overrun0 !== m_ovr || o_overrun8 !== m_ovr) begin
               n_err++; $display("FAIL rnd_overrun b=%0d: got %b/%b want %b", b, o_overrun0, o_overrun8, m_ovr);
            end
            if (o_taps_I0 !== pack_exp(0, 0) || o_taps_Q0 !== pack_exp(0, 1) ||
                o_taps_I8 !== pack_exp(1, 0) || o_taps_Q8 !== pack_exp(1, 1)) begin
               n_err++; $display("FAIL rnd_taps b=%0d: got %h %h %h %h want %h %h %h %h", b,
                                 o_taps_I0, o_taps_Q0, o_taps_I8, o_taps_Q8,
                                 pack_exp(0, 0), pack_exp(0, 1), pack_exp(1, 0), pack_exp(1, 1));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_update();
      test_lms_disabled();
      test_overrun();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
